// File: rtl/operand_fetch.sv
// operand_fetch -- operand read stage with a 2-entry skid buffer.
//
// Purpose:
//   Forwards the request's mode and read addresses straight to the register
//   file. On accept it captures the mode plus the three returned operands
//   into a two-entry buffer. "main" drives the outputs and "skid" absorbs one
//   extra entry while downstream stalls. In_Ready depends only on registered
//   state, so there is no combinational path from Out_Ready to In_Ready.
//
// Ports:
//   Clk, Rst                         clock, asynchronous active-low reset
//   In_Valid/In_Ready                upstream handshake
//   In_M, In_RA/RB/RC                request mode and read addresses
//   M, R_Addr_A/B/C                  register-file read request (pass-through)
//   R_Data_A/B/C                     combinational register-file read data
//   Write_Reg, W_M, W_Addr, W_Data   snoop of the register-file write port
//   Out_Valid/Out_Ready              downstream handshake
//   Out_M, Out_A/B/C                 presented entry (always from main)
//
// Configuration:
//   OPERAND_FORWARD_EN  when defined, a snooped write whose mode and address
//                       match an operand replaces that operand, both at the
//                       accept edge and for entries already held. Without
//                       it, held entries never change.

module operand_fetch #(
  parameter int ADDR = 4,
  parameter int SIZE = 32
) (
  input  logic            Clk,
  input  logic            Rst,
  // upstream request
  input  logic            In_Valid,
  output logic            In_Ready,
  input  logic [4:0]      In_M,
  input  logic [ADDR-1:0] In_RA,
  input  logic [ADDR-1:0] In_RB,
  input  logic [ADDR-1:0] In_RC,
  // register-file read
  output logic [4:0]      M,
  output logic [ADDR-1:0] R_Addr_A,
  output logic [ADDR-1:0] R_Addr_B,
  output logic [ADDR-1:0] R_Addr_C,
  input  logic [SIZE-1:0] R_Data_A,
  input  logic [SIZE-1:0] R_Data_B,
  input  logic [SIZE-1:0] R_Data_C,
  // write snoop
  input  logic            Write_Reg,
  input  logic [4:0]      W_M,
  input  logic [ADDR-1:0] W_Addr,
  input  logic [SIZE-1:0] W_Data,
  // downstream
  output logic            Out_Valid,
  input  logic            Out_Ready,
  output logic [4:0]      Out_M,
  output logic [SIZE-1:0] Out_A,
  output logic [SIZE-1:0] Out_B,
  output logic [SIZE-1:0] Out_C
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  // Addresses only need to travel with an entry when held entries can be
  // refreshed by later writes.
  typedef struct packed {
    logic [4:0]      m;
`ifdef OPERAND_FORWARD_EN
    logic [ADDR-1:0] ra;
    logic [ADDR-1:0] rb;
    logic [ADDR-1:0] rc;
`endif
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    logic [SIZE-1:0] c;
  } entry_t;

  logic [1:0] state;
  entry_t     main_q;
  entry_t     skid_q;
  entry_t     in_entry;
  entry_t     main_cur;
  entry_t     skid_cur;
  logic       accept;

`ifdef OPERAND_FORWARD_EN
  // Each operand is matched independently, so an entry that names the same
  // register twice gets every copy replaced.
  function automatic entry_t refresh(input entry_t          e,
                                     input logic            wr,
                                     input logic [4:0]      wm,
                                     input logic [ADDR-1:0] waddr,
                                     input logic [SIZE-1:0] wdata);
    entry_t r;
    r = e;
    if (wr && (wm == e.m)) begin
      if (waddr == e.ra) r.a = wdata;
      if (waddr == e.rb) r.b = wdata;
      if (waddr == e.rc) r.c = wdata;
    end
    return r;
  endfunction
`endif

  assign M        = In_M;
  assign R_Addr_A = In_RA;
  assign R_Addr_B = In_RB;
  assign R_Addr_C = In_RC;

  assign In_Ready  = (state != FULL);
  assign Out_Valid = (state == ONE) || (state == FULL);
  assign accept    = In_Valid && In_Ready;

  assign Out_M = main_q.m;
  assign Out_A = main_q.a;
  assign Out_B = main_q.b;
  assign Out_C = main_q.c;

  always_comb begin
    in_entry   = '0;
    in_entry.m = In_M;
    in_entry.a = R_Data_A;
    in_entry.b = R_Data_B;
    in_entry.c = R_Data_C;
`ifdef OPERAND_FORWARD_EN
    in_entry.ra = In_RA;
    in_entry.rb = In_RB;
    in_entry.rc = In_RC;
    in_entry = refresh(in_entry, Write_Reg, W_M, W_Addr, W_Data);
    main_cur = refresh(main_q,   Write_Reg, W_M, W_Addr, W_Data);
    skid_cur = refresh(skid_q,   Write_Reg, W_M, W_Addr, W_Data);
`else
    main_cur = main_q;
    skid_cur = skid_q;
`endif
  end

  // Buffer stage: main is only rewritten while it holds a live entry, so
  // the outputs of an empty buffer stay put.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_q <= in_entry;
            state  <= ONE;
          end
        end
        ONE: begin
          if (accept && Out_Ready) begin
            main_q <= in_entry;
          end else if (accept) begin
            main_q <= main_cur;
            skid_q <= in_entry;
            state  <= FULL;
          end else if (Out_Ready) begin
            state <= EMPTY;
          end else begin
            main_q <= main_cur;
          end
        end
        FULL: begin
          if (Out_Ready) begin
            main_q <= skid_cur;
            state  <= ONE;
          end else begin
            main_q <= main_cur;
            skid_q <= skid_cur;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;

  localparam int AW = 4;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    in_m;
  logic [AW-1:0] in_ra, in_rb, in_rc;
  logic [4:0]    m;
  logic [AW-1:0] r_addr_a, r_addr_b, r_addr_c;
  logic [DW-1:0] r_data_a, r_data_b, r_data_c;
  logic          write_reg;
  logic [4:0]    w_m;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic          out_valid;
  logic          out_ready;
  logic [4:0]    out_m;
  logic [DW-1:0] out_a, out_b, out_c;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [4:0]    m;
    logic [AW-1:0] ra, rb, rc;
    logic [DW-1:0] a, b, c;
  } ent_t;

  ent_t mq[$];

`ifdef OPERAND_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  operand_fetch #(.ADDR(AW), .SIZE(DW)) dut (
    .Clk(clk), .Rst(rst),
    .In_Valid(in_valid), .In_Ready(in_ready), .In_M(in_m),
    .In_RA(in_ra), .In_RB(in_rb), .In_RC(in_rc),
    .M(m), .R_Addr_A(r_addr_a), .R_Addr_B(r_addr_b), .R_Addr_C(r_addr_c),
    .R_Data_A(r_data_a), .R_Data_B(r_data_b), .R_Data_C(r_data_c),
    .Write_Reg(write_reg), .W_M(w_m), .W_Addr(w_addr), .W_Data(w_data),
    .Out_Valid(out_valid), .Out_Ready(out_ready), .Out_M(out_m),
    .Out_A(out_a), .Out_B(out_b), .Out_C(out_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // A write updates an operand when mode and address both match.
  function automatic ent_t snoop(input ent_t e);
    ent_t r = e;
    if (FWD && write_reg && w_m == e.m) begin
      if (w_addr == e.ra) r.a = w_data;
      if (w_addr == e.rb) r.b = w_data;
      if (w_addr == e.rc) r.c = w_data;
    end
    return r;
  endfunction

  // Queue model of a 2-deep FIFO: pop when downstream takes, push on accept.
  task automatic model_edge();
    ent_t e;
    bit   acc;
    acc  = in_valid && (mq.size() < 2);
    e.m  = in_m;  e.ra = in_ra; e.rb = in_rb; e.rc = in_rc;
    e.a  = r_data_a; e.b = r_data_b; e.c = r_data_c;
    e    = snoop(e);
    foreach (mq[i]) mq[i] = snoop(mq[i]);
    if (out_ready && mq.size() > 0) void'(mq.pop_front());
    if (acc) mq.push_back(e);
  endtask

  task automatic check_all();
    chk("out_valid", out_valid, mq.size() > 0);
    chk("in_ready", in_ready, mq.size() < 2);
    chk("pass_m", m, in_m);
    chk("pass_ra", r_addr_a, in_ra);
    chk("pass_rc", r_addr_c, in_rc);
    if (mq.size() > 0) begin
      chk("out_m", out_m, mq[0].m);
      chk("out_a", out_a, mq[0].a);
      chk("out_b", out_b, mq[0].b);
      chk("out_c", out_c, mq[0].c);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    in_valid = 0; write_reg = 0; out_ready = 1;
    in_m = 0; in_ra = 0; in_rb = 0; in_rc = 0;
    r_data_a = 0; r_data_b = 0; r_data_c = 0;
    w_m = 0; w_addr = 0; w_data = 0;
  endtask

  initial begin
    rst = 0;
    idle();
    #3;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_out_a", out_a, 0);
    chk("rst_out_m", out_m, 0);
    #9 rst = 1;   // released between edges

    // streaming, one-cycle latency, first accept right after reset
    out_ready = 1; in_valid = 1; in_rb = 1; in_rc = 2;
    for (int k = 1; k <= 3; k++) begin
      r_data_a = k;
      step();
      chk("stream_a", out_a, k);
      chk("stream_valid", out_valid, 1'b1);
      chk("stream_ready", in_ready, 1'b1);
    end
    in_valid = 0;
    step();
    chk("stream_drained", out_valid, 1'b0);

    // stall fills skid, then drain in order
    out_ready = 0; in_valid = 1; r_data_b = 8;
    step();
    r_data_b = 9;
    step();
    in_valid = 0;
    chk("full_ready", in_ready, 1'b0);
    chk("full_b0", out_b, 8);
    out_ready = 1;
    step();
    chk("pop1_b", out_b, 9);
    chk("pop1_ready", in_ready, 1'b1);
    step();
    chk("pop2_valid", out_valid, 1'b0);

    // asynchronous reset while FULL and stalled
    out_ready = 0; in_valid = 1; r_data_a = 32'h55;
    step(); step();
    in_valid = 0;
    chk("prerst_full", in_ready, 1'b0);
    #3 rst = 0;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_ready", in_ready, 1'b1);
    chk("arst_out_a", out_a, 0);
    mq.delete();
    #2 rst = 1;
    idle();

    // forwarding at the accept edge
    in_valid = 1; in_m = 5'b10001; in_ra = 8; in_rb = 1; in_rc = 2;
    r_data_a = 2; write_reg = 1; w_m = 5'b10001; w_addr = 8; w_data = 5;
    step();
    chk("fwd_accept_a", out_a, FWD ? 5 : 2);
    w_m = 5'b10010;
    step();
    chk("fwd_modemiss_a", out_a, 2);
    idle(); step();

    // write while an entry waits in skid
    out_ready = 0; in_valid = 1; in_m = 5'b00000; in_rc = 1; r_data_c = 4;
    step();
    in_m = 5'b10000; in_rc = 13; r_data_c = 3;
    step();
    in_valid = 0; write_reg = 1; w_m = 5'b10000; w_addr = 13; w_data = 7;
    step();
    write_reg = 0; out_ready = 1;
    step();
    chk("skid_fwd_c", out_c, FWD ? 7 : 3);
    idle(); step();

    // duplicate addresses both forwarded
    in_valid = 1; in_m = 5'b00011; in_ra = 0; in_rb = 0; in_rc = 5;
    r_data_a = 1; r_data_b = 2; r_data_c = 3;
    write_reg = 1; w_m = 5'b00011; w_addr = 0; w_data = 6;
    step();
    chk("dup_a", out_a, FWD ? 6 : 1);
    chk("dup_b", out_b, FWD ? 6 : 2);
    idle(); step();

    // randomized traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_m      = 5'($urandom_range(0, 1));
      in_ra     = AW'($urandom_range(0, 3));
      in_rb     = AW'($urandom_range(0, 3));
      in_rc     = AW'($urandom_range(0, 3));
      r_data_a  = $urandom; r_data_b = $urandom; r_data_c = $urandom;
      write_reg = $urandom_range(0, 1);
      w_m       = 5'($urandom_range(0, 1));
      w_addr    = AW'($urandom_range(0, 3));
      w_data    = $urandom;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 The block SHALL have parameter ADDR, default 4, register address width.
REQ-002 The block SHALL have parameter SIZE, default 32, register data width.
REQ-003 The block SHALL have port Clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port Rst, input, 1, reset, asynchronous and active-low.
REQ-005 The block SHALL have upstream request ports: In_Valid in 1; In_Ready out 1; In_M in 5 (mode); In_RA, In_RB, In_RC in ADDR each (read addresses).
REQ-006 The block SHALL have register-file read ports: M out 5; R_Addr_A, R_Addr_B, R_Addr_C out ADDR each; R_Data_A, R_Data_B, R_Data_C in SIZE each, combinational read data.
REQ-007 The block SHALL have write-snoop ports: Write_Reg in 1; W_M in 5; W_Addr in ADDR; W_Data in SIZE, mirroring the register-file write port.
REQ-008 The block SHALL have downstream ports: Out_Valid out 1; Out_Ready in 1; Out_M out 5; Out_A, Out_B, Out_C out SIZE each.

Function
REQ-009 M, R_Addr_A/B/C SHALL equal In_M, In_RA/RB/RC combinationally, every cycle.
REQ-010 Accept SHALL occur on a rising edge where In_Valid=1 and In_Ready=1; the captured entry is {In_M, operand values A/B/C}.
REQ-011 Latency SHALL be 1 cycle: an entry accepted at edge N is presented with Out_Valid=1 after edge N when the output register is free.
REQ-012 Storage SHALL be a 2-entry skid buffer (main = output register, skid = overflow) with states EMPTY, ONE, FULL.
REQ-013 EMPTY: accept -> ONE (entry into main).
REQ-014 ONE: accept and Out_Ready=1 -> ONE (main replaced); accept and Out_Ready=0 -> FULL (entry into skid); no accept and Out_Ready=1 -> EMPTY; else hold.
REQ-015 FULL: Out_Ready=1 -> ONE (skid moves to main); else hold; no accept is possible in FULL.
REQ-016 In_Ready SHALL be 1 exactly when state is not FULL, derived from registered state only (no combinational path from Out_Ready).
REQ-017 Out_Valid SHALL be 1 exactly when state is ONE or FULL; Out_M/A/B/C SHALL come from main.
REQ-018 Out_M/A/B/C SHALL hold stable while Out_Valid=1 and Out_Ready=0, except for forwarding refresh (REQ-022).
REQ-019 Entry order SHALL be preserved; no entry dropped or duplicated.

Reset
REQ-020 Rst=0 SHALL immediately force state EMPTY, Out_Valid=0, In_Ready=1, Out_M=0, Out_A/B/C=0, skid contents 0, regardless of Clk; in-flight entries are discarded.
REQ-021 After Rst rises, the first accept SHALL be possible at the next rising edge.

Configuration
REQ-022 With macro OPERAND_FORWARD_EN defined, a snooped write (Write_Reg=1, W_M=In_M, W_Addr=In_Rx) at the accept edge SHALL supply W_Data as that operand instead of R_Data_x; every held entry (main, skid) whose mode and address match a write at any edge SHALL have that operand replaced by W_Data at the same edge; matches are per operand, so duplicate addresses all update.
REQ-023 Without OPERAND_FORWARD_EN, operands SHALL be R_Data_x sampled at the accept edge and held entries SHALL never change; hazard avoidance is the issuer's responsibility.

Verification
REQ-024 Rst=0 mid-FULL with Out_Ready=0 -> next sample: Out_Valid=0, In_Ready=1, Out_A=0.
REQ-025 Stream 3 requests, Out_Ready=1, R_Data_A=1,2,3 -> Out_A=1,2,3 on consecutive cycles, 1-cycle latency, In_Ready held 1.
REQ-026 Out_Ready=0, accept 2 requests (R_Data_B=8, then 9) -> state FULL, In_Ready=0; Out_Ready=1 -> Out_B=8 then 9, In_Ready=1 after first pop.
REQ-027 FORWARD_EN: accept In_RA=8, In_M=5'b10001, R_Data_A=2, with Write_Reg=1, W_M=5'b10001, W_Addr=8, W_Data=5 at same edge -> Out_A=5; same with W_M=5'b10010 -> Out_A=2.
REQ-028 FORWARD_EN: entry in skid with In_RC=13, In_M=5'b10000; write W_Addr=13, W_M=5'b10000, W_Data=7 while held -> popped Out_C=7; without macro -> original R_Data_C.
REQ-029 Accept with In_RA=In_RB=0 and matching write W_Data=6 (FORWARD_EN) -> Out_A=Out_B=6.
